// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and data memory (slave):
// req/gnt request phase followed by an rvalid response for both reads and writes.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX/MEM load/store controls -> req/gnt/rvalid bus access,
// formatted load data to MEM/WB. Optional misalignment trap via LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid_i,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  input  logic [2:0]             funct3_i,
  input  logic [31:0]            alu_out_i,
  input  logic [31:0]            wdata_i,
  output logic [31:0]            alu_out_o,
  output logic [31:0]            mem_rdata_o,
  output logic                   stall_o,
  output logic                   misalign_o,
  mem_stage_lsu_if.master        dmem
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  size_e       size;
  logic        unsigned_ld;
  logic [1:0]  lane_off;
  logic        acc;
  logic        misal;
  logic        go;
  logic        load_en;
  logic [31:0] rdata_sh;
  logic [31:0] rdata_fmt;

  assign alu_out_o   = alu_out_i;
  assign mem_rdata_o = rdata_q;

  always_comb begin
    size        = SZ_W;
    unsigned_ld = 1'b0;
    case (funct3_i)
      3'b000:  size = SZ_B;
      3'b001:  size = SZ_H;
      3'b100:  begin size = SZ_B; unsigned_ld = 1'b1; end
      3'b101:  begin size = SZ_H; unsigned_ld = 1'b1; end
      default: size = SZ_W;
    endcase
  end

  // Without the trap, the low address bits below the access size are simply dropped.
  always_comb begin
    lane_off = 2'b00;
    case (size)
      SZ_B:    lane_off = alu_out_i[1:0];
      SZ_H:    lane_off = {alu_out_i[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  end

  assign acc = ex_valid_i & (mem_read_i | mem_write_i);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = ((size == SZ_H) && alu_out_i[0]) ||
                 ((size == SZ_W) && (alu_out_i[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign go = acc & ~misal;

  // Request-phase bus fields are pure functions of the held EX/MEM inputs.
  assign dmem.we   = mem_write_i;
  assign dmem.addr = {alu_out_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    dmem.be    = 4'b1111;
    dmem.wdata = wdata_i;
    case (size)
      SZ_B: begin
        dmem.be    = 4'b0001 << lane_off;
        dmem.wdata = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        dmem.be    = 4'b0011 << lane_off;
        dmem.wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        dmem.be    = 4'b1111;
        dmem.wdata = wdata_i;
      end
    endcase
  end

  assign rdata_sh = dmem.rdata >> {lane_off, 3'b000};

  always_comb begin
    rdata_fmt = rdata_sh;
    case (size)
      SZ_B:    rdata_fmt = {{24{~unsigned_ld & rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_H:    rdata_fmt = {{16{~unsigned_ld & rdata_sh[15]}}, rdata_sh[15:0]};
      default: rdata_fmt = rdata_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go && dmem.gnt) state_d = S_WAIT;
      S_WAIT:  if (dmem.rvalid)    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even if EX/MEM still shows an access.
  always_comb begin
    dmem.req   = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    load_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem.req   = go & rst_n;
        stall_o    = go & rst_n;
        misalign_o = acc & misal & rst_n;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        load_en = dmem.rvalid & mem_read_i;
      end
      default: begin
        dmem.req = 1'b0;
        stall_o  = 1'b0;
      end
    endcase
  end

  assign rdata_d = load_en ? rdata_fmt : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu: transaction-level model of the access timeline,
// byte lanes and load formatting, checked every cycle, plus literal directed cases.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu, wdata;
  logic [31:0] alu_out_o, mem_rdata_o;
  logic        stall_o, misalign_o;

  mem_stage_lsu_if #(.ADDR_W(32)) dmem ();

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid_i  (ex_valid),
    .mem_read_i  (mem_read),
    .mem_write_i (mem_write),
    .funct3_i    (funct3),
    .alu_out_i   (alu),
    .wdata_i     (wdata),
    .alu_out_o   (alu_out_o),
    .mem_rdata_o (mem_rdata_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .dmem        (dmem.master)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Expectations published by the stimulus process, consumed by the compare process.
  logic        chk_en, chk_bus;
  logic        exp_req, exp_stall, exp_mis, exp_we;
  logic [31:0] exp_rd, exp_addr, exp_wd;
  logic [3:0]  exp_be;
  logic        lit_valid;
  string       lit_name;
  logic [31:0] lit_act, lit_exp;

  logic [31:0] model_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        obs_stall [16];
  int          obs_n;
  logic        obs_we, obs_req, obs_mis;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd, obs_rd, obs_addr;

  // ---------------- reference model ----------------
  function automatic int unsigned m_lane(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return a % 4;
      3'b001, 3'b101: return ((a % 4) / 2) * 2;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return 4'(1 << m_lane(f3, a));
      3'b001, 3'b101: return 4'(3 << m_lane(f3, a));
      default:        return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: return (wd % 256) * 32'h01010101;
      3'b001, 3'b101: return (wd % 65536) * 32'h00010001;
      default:        return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] rdv);
    logic [31:0] v;
    v = rdv >> (8 * m_lane(f3, a));
    case (f3)
      3'b000:  return ((v % 256) >= 128) ? (v % 256) + 32'hFFFFFF00 : v % 256;
      3'b100:  return v % 256;
      3'b001:  return ((v % 65536) >= 32768) ? (v % 65536) + 32'hFFFF0000 : v % 65536;
      3'b101:  return v % 65536;
      default: return rdv;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return TRAP && ((a % 2) != 0);
      default:        return TRAP && ((a % 4) != 0);
    endcase
  endfunction

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",     {31'b0, stall_o},    {31'b0, exp_stall});
      chk("req",       {31'b0, dmem.req},   {31'b0, exp_req});
      chk("misalign",  {31'b0, misalign_o}, {31'b0, exp_mis});
      chk("mem_rdata", mem_rdata_o,         exp_rd);
      chk("alu_out",   alu_out_o,           alu);
      if (chk_bus) begin
        chk("we",    {31'b0, dmem.we}, {31'b0, exp_we});
        chk("addr",  dmem.addr,        exp_addr);
        chk("be",    {28'b0, dmem.be}, {28'b0, exp_be});
        chk("wdata", dmem.wdata,       exp_wd);
      end
      if (lit_valid) chk(lit_name, lit_act, lit_exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bubble();
    ex_valid = 1'($urandom_range(0, 1));
    if (ex_valid) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else begin
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = ~mem_read;
    end
    funct3      = 3'($urandom_range(0, 7));
    alu         = $urandom;
    wdata       = $urandom;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'($urandom_range(0, 1));
    dmem.rdata  = $urandom;
    exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; chk_bus = 1'b0;
    exp_rd  = model_rd;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    lit_name  = nm;
    lit_act   = act;
    lit_exp   = expv;
    lit_valid = 1'b1;
    bubble();
    lit_valid = 1'b0;
  endtask

  // g = cycles of gnt low before the grant cycle, r = cycles from gnt to rvalid.
  task automatic run_txn(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input int g, input int r);
    int   last;
    ex_valid = 1'b1; mem_read = rd; mem_write = ~rd;
    funct3 = f3; alu = a; wdata = wd;
    exp_we   = ~rd;
    exp_addr = {a[31:2], 2'b00};
    exp_be   = m_be(f3, a);
    exp_wd   = m_wd(f3, wd);
    exp_rd   = model_rd;
    if (m_mis(f3, a)) begin
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = $urandom;
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b1; chk_bus = 1'b0;
      #2;
      obs_stall[0] = stall_o; obs_mis = misalign_o; obs_req = dmem.req; obs_n = 1;
      @(posedge clk); #1;
      return;
    end
    exp_mis = 1'b0;
    last    = g + r + 1;
    for (int k = 0; k <= last; k++) begin
      dmem.gnt = (k == g);
      if (k == g + r) begin
        dmem.rvalid = 1'b1;
        dmem.rdata  = rdv;
      end else begin
        dmem.rvalid = ((k < g) || (k == last)) ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem.rdata  = $urandom;
      end
      exp_req   = (k <= g);
      exp_stall = (k <= g + r);
      chk_bus   = exp_req;
      if (k == last && rd) model_rd = m_ld(f3, a, rdv);
      exp_rd = model_rd;
      #2;
      if (k < 16) obs_stall[k] = stall_o;
      if (k == 0) begin
        obs_we = dmem.we; obs_be = dmem.be; obs_wd = dmem.wdata;
        obs_addr = dmem.addr; obs_req = dmem.req; obs_mis = misalign_o;
      end
      if (k == last) obs_rd = mem_rdata_o;
      @(posedge clk); #1;
    end
    obs_n = last + 1;
  endtask

  initial begin
    int stalls;
    lit_valid = 1'b0; lit_name = ""; lit_act = 0; lit_exp = 0;
    model_rd  = 32'h0;
    rst_n = 1'b0;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu = 32'h40; wdata = 32'h0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    exp_we = 1'b0; exp_addr = 0; exp_be = 0; exp_wd = 0; chk_bus = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ex_valid = 1'b0;
    rst_n = 1'b1;
    bubble();

    run_txn(1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
    lit("lw_stall_seq", {29'b0, obs_stall[0], obs_stall[1], obs_stall[2]}, 32'b110);
    lit("lw_be", {28'b0, obs_be}, 32'hF);
    lit("lw_rdata_in_done", obs_rd, 32'hDEADBEEF);

    run_txn(1'b1, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 1);
    lit("lb_rdata", obs_rd, 32'hFFFFFF80);
    run_txn(1'b1, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 2);
    lit("lbu_rdata", obs_rd, 32'h00000080);
    run_txn(1'b1, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 1);
    lit("lhu_rdata", obs_rd, 32'h00008012);

    run_txn(1'b0, 3'b001, 32'h102, 32'h1234ABCD, 32'h55555555, 0, 1);
    lit("sh_we", {31'b0, obs_we}, 32'h1);
    lit("sh_be", {28'b0, obs_be}, 32'hC);
    lit("sh_wdata", obs_wd, 32'hABCDABCD);
    lit("sh_rdata_kept", obs_rd, 32'h00008012);

    run_txn(1'b1, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, 3, 1);
    stalls = 0;
    for (int i = 0; i < obs_n; i++) stalls += int'(obs_stall[i]);
    lit("gnt_low_stall_cycles", stalls, 32'd5);

    run_txn(1'b1, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 1);
    if (TRAP) begin
      lit("mis_flag", {31'b0, obs_mis}, 32'h1);
      lit("mis_req", {31'b0, obs_req}, 32'h0);
      lit("mis_stall", {31'b0, obs_stall[0]}, 32'h0);
    end else begin
      lit("mis_addr", obs_addr, 32'h100);
      lit("mis_be", {28'b0, obs_be}, 32'hF);
      lit("mis_rdata", obs_rd, 32'h11223344);
    end

    // Reset while waiting for the response; the late rvalid must be ignored.
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu = 32'h200; wdata = 32'h0;
    dmem.gnt = 1'b1; dmem.rvalid = 1'b0;
    exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; chk_bus = 1'b1;
    exp_we = 1'b0; exp_addr = 32'h200; exp_be = 4'hF; exp_wd = 32'h0; exp_rd = model_rd;
    @(posedge clk); #1;
    dmem.gnt = 1'b0; rst_n = 1'b0; model_rd = 32'h0;
    exp_req = 1'b0; exp_stall = 1'b0; chk_bus = 1'b0; exp_rd = 32'h0;
    @(posedge clk); #1;
    ex_valid = 1'b0; rst_n = 1'b1;
    dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    bubble();

    for (int t = 0; t < 300; t++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
      if ($urandom_range(0, 1) == 1) bubble();
    end
    bubble();

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
